// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential unsigned multiplier / restoring divider, one bit per cycle.
// Multiply is shift-add, LSB first; divide is shift-subtract, MSB first; all outputs are registered.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic [2:0]       flag
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             busy_d, done_d;
    logic [WIDTH-1:0] res_hi_d, res_lo_d;
    logic [2:0]       flag_d;
    logic [WIDTH:0]   sum, shifted, diff;
    logic [WIDTH-1:0] nhi, nlo;
    logic             last, div0, accept;

    // hi_q/lo_q hold the {upper, lower} accumulator for multiply and {remainder, dividend->quotient} for divide
    assign last    = cnt_q == CW'(WIDTH - 1);
    assign accept  = state_q == IDLE && start;
    assign div0    = op && data_b == '0;
    assign sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign shifted = {hi_q, lo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, b_q};
    assign nhi     = op_q ? (diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
    assign nlo     = op_q ? {lo_q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], lo_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = accept ? (div0 ? DONE : RUN)
                : (state_q == RUN && last) ? DONE
                : (state_q == DONE) ? IDLE : state_q;
    end

    always_comb begin
        op_d   = accept ? op : op_q;
        hi_d   = accept ? '0 : (state_q == RUN) ? nhi : hi_q;
        lo_d   = accept ? data_a : (state_q == RUN) ? nlo : lo_q;
        b_d    = accept ? data_b : b_q;
        cnt_d  = accept ? '0 : (state_q == RUN) ? cnt_q + CW'(1) : cnt_q;
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
        res_hi_d = result_hi;
        res_lo_d = result_lo;
        flag_d   = flag;
        if (accept && div0) begin
            res_hi_d = data_a;
            res_lo_d = '1;
            flag_d   = 3'b010;
        end else if (state_q == RUN && last) begin
            res_hi_d = nhi;
            res_lo_d = nlo;
            flag_d   = (!op_q && nhi != '0) ? 3'b011 : 3'b000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            op_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
            flag      <= 3'b000;
        end else begin
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            busy      <= busy_d;
            done      <= done_d;
            result_hi <= res_hi_d;
            result_lo <= res_lo_d;
            flag      <= flag_d;
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed checks of muldiv_seq (WIDTH=32) against hand-computed results.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        reset, start, op;
    logic [31:0] data_a, data_b;
    logic        busy, done;
    logic [31:0] result_hi, result_lo;
    logic [2:0]  flag;
    int          checks = 0;
    int          failures = 0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .data_a(data_a), .data_b(data_b),
        .busy(busy), .done(done),
        .result_hi(result_hi), .result_lo(result_lo), .flag(flag)
    );

    always #5 clk = ~clk;

    // waits for IDLE, pulses start for one edge, scrambles operands, returns edges-to-done (-1 on timeout)
    task automatic launch(input logic o, input logic [31:0] a, input logic [31:0] b, output int lat);
        int g;
        g = 0;
        @(negedge clk);
        while (busy && g < 100) begin
            @(negedge clk);
            g++;
        end
        op = o; data_a = a; data_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; data_a = 32'hDEAD_BEEF; data_b = 32'h0BAD_F00D;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; op = 1'b0; data_a = '0; data_b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (result_hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", result_hi); end
        checks++; if (result_lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", result_lo); end
        checks++; if (flag !== 3'b000) begin failures++; $display("FAIL reset_flag got=%b exp=000", flag); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mul;
        int lat;
        launch(1'b0, 32'd7, 32'd6, lat);
        checks++; if (lat != 33) begin failures++; $display("FAIL mul7x6_latency got=%0d exp=33", lat); end
        checks++; if (result_hi !== 32'd0) begin failures++; $display("FAIL mul7x6_hi got=%h exp=0", result_hi); end
        checks++; if (result_lo !== 32'd42) begin failures++; $display("FAIL mul7x6_lo got=%0d exp=42", result_lo); end
        checks++; if (flag !== 3'b000) begin failures++; $display("FAIL mul7x6_flag got=%b exp=000", flag); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mul7x6_busy_in_done got=%b exp=1", busy); end
        launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        checks++; if (result_hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mulmax_hi got=%h exp=fffffffe", result_hi); end
        checks++; if (result_lo !== 32'h0000_0001) begin failures++; $display("FAIL mulmax_lo got=%h exp=00000001", result_lo); end
        checks++; if (flag !== 3'b011) begin failures++; $display("FAIL mulmax_flag got=%b exp=011", flag); end
        launch(1'b0, 32'h0001_0000, 32'h0001_0000, lat);
        checks++; if (result_hi !== 32'h1 || result_lo !== 32'h0) begin failures++; $display("FAIL mul2p32 got=%h_%h exp=00000001_00000000", result_hi, result_lo); end
        checks++; if (flag !== 3'b011) begin failures++; $display("FAIL mul2p32_flag got=%b exp=011", flag); end
    endtask

    task automatic test_div;
        int lat;
        launch(1'b1, 32'd100, 32'd7, lat);
        checks++; if (lat != 33) begin failures++; $display("FAIL div100_7_latency got=%0d exp=33", lat); end
        checks++; if (result_lo !== 32'd14) begin failures++; $display("FAIL div100_7_q got=%0d exp=14", result_lo); end
        checks++; if (result_hi !== 32'd2) begin failures++; $display("FAIL div100_7_r got=%0d exp=2", result_hi); end
        checks++; if (flag !== 3'b000) begin failures++; $display("FAIL div100_7_flag got=%b exp=000", flag); end
        launch(1'b1, 32'd5, 32'd9, lat);
        checks++; if (result_lo !== 32'd0 || result_hi !== 32'd5) begin failures++; $display("FAIL div5_9 got q=%0d r=%0d exp q=0 r=5", result_lo, result_hi); end
        launch(1'b1, 32'hFFFF_FFFF, 32'd1, lat);
        checks++; if (result_lo !== 32'hFFFF_FFFF || result_hi !== 32'd0) begin failures++; $display("FAIL divmax_1 got q=%h r=%h exp q=ffffffff r=0", result_lo, result_hi); end
        launch(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        checks++; if (result_lo !== 32'd1 || result_hi !== 32'd0) begin failures++; $display("FAIL divmax_max got q=%h r=%h exp q=1 r=0", result_lo, result_hi); end
        launch(1'b1, 32'h8000_0000, 32'd3, lat);
        checks++; if (result_lo !== 32'h2AAA_AAAA || result_hi !== 32'd2) begin failures++; $display("FAIL div2p31_3 got q=%h r=%h exp q=2aaaaaaa r=2", result_lo, result_hi); end
    endtask

    task automatic test_div0;
        int lat;
        launch(1'b1, 32'd1234, 32'd0, lat);
        checks++; if (lat != 1) begin failures++; $display("FAIL div0_latency got=%0d exp=1", lat); end
        checks++; if (result_lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div0_q got=%h exp=ffffffff", result_lo); end
        checks++; if (result_hi !== 32'd1234) begin failures++; $display("FAIL div0_r got=%0d exp=1234", result_hi); end
        checks++; if (flag !== 3'b010) begin failures++; $display("FAIL div0_flag got=%b exp=010", flag); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL div0_after got done=%b busy=%b exp 0 0", done, busy); end
    endtask

    task automatic test_reset_abort;
        int lat, n;
        n = 0;
        @(negedge clk);
        op = 1'b0; data_a = 32'd9; data_b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_ctl got busy=%b done=%b exp 0 0", busy, done); end
        checks++; if (result_hi !== 32'd0 || result_lo !== 32'd0 || flag !== 3'b000) begin failures++; $display("FAIL abort_results got %h %h %b exp 0 0 000", result_hi, result_lo, flag); end
        @(negedge clk);
        reset = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) n++;
        end
        checks++; if (n != 0) begin failures++; $display("FAIL abort_stale_done got=%0d exp=0", n); end
        launch(1'b0, 32'd3, 32'd3, lat);
        checks++; if (lat != 33 || result_lo !== 32'd9) begin failures++; $display("FAIL abort_then_mul got lat=%0d lo=%0d exp lat=33 lo=9", lat, result_lo); end
    endtask

    task automatic test_done_start_ignored;
        int lat;
        launch(1'b0, 32'd2, 32'd3, lat);
        start = 1'b1; op = 1'b1; data_a = 32'd5; data_b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL start_in_done got busy=%b done=%b exp 0 0", busy, done); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (result_lo !== 32'd6 || result_hi !== 32'd0 || flag !== 3'b000) begin failures++; $display("FAIL idle_hold got %h %h %b exp 0 6 000", result_hi, result_lo, flag); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_start_held;
        int nd, glitch;
        logic exp_busy;
        nd = 0; glitch = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int e = 0; e < 102; e++) begin
            @(negedge clk);
            start = 1'b1; op = 1'b0; data_a = 32'(100 + e); data_b = 32'd3;
            @(posedge clk); #1;
            exp_busy = (e % 34) != 33;
            if (busy !== exp_busy) glitch++;
            if (done) begin
                checks++; if (e != 32 + 34 * nd) begin failures++; $display("FAIL held_done_edge got=%0d exp=%0d", e, 32 + 34 * nd); end
                checks++; if (result_lo !== 32'(3 * (100 + 34 * nd))) begin failures++; $display("FAIL held_result got=%0d exp=%0d", result_lo, 3 * (100 + 34 * nd)); end
                nd++;
            end
        end
        start = 1'b0;
        checks++; if (nd != 3) begin failures++; $display("FAIL held_done_count got=%0d exp=3", nd); end
        checks++; if (glitch != 0) begin failures++; $display("FAIL held_busy_pattern got=%0d bad cycles exp=0", glitch); end
    endtask

    task automatic test_back_to_back;
        int lat;
        launch(1'b0, 32'h0000_FFFF, 32'h0000_FFFF, lat);
        checks++; if (result_hi !== 32'd0 || result_lo !== 32'hFFFE_0001 || flag !== 3'b000) begin failures++; $display("FAIL b2b_mul got %h %h %b exp 0 fffe0001 000", result_hi, result_lo, flag); end
        launch(1'b1, 32'd5, 32'd0, lat);
        checks++; if (lat != 1 || result_hi !== 32'd5 || result_lo !== 32'hFFFF_FFFF || flag !== 3'b010) begin failures++; $display("FAIL b2b_div0 got lat=%0d %h %h %b exp 1 5 ffffffff 010", lat, result_hi, result_lo, flag); end
        launch(1'b0, 32'h1234_5678, 32'h10, lat);
        checks++; if (result_hi !== 32'd1 || result_lo !== 32'h2345_6780 || flag !== 3'b011) begin failures++; $display("FAIL b2b_mul_ovf got %h %h %b exp 1 23456780 011", result_hi, result_lo, flag); end
        launch(1'b1, 32'd1000, 32'd33, lat);
        checks++; if (result_lo !== 32'd30 || result_hi !== 32'd10 || flag !== 3'b000) begin failures++; $display("FAIL b2b_div got q=%0d r=%0d %b exp 30 10 000", result_lo, result_hi, flag); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div0();
        test_reset_abort();
        test_done_start_ignored();
        test_start_held();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
